// File: rtl/tx_frame_buffer.sv
// Output stage of the FIR datapath: buffers filtered samples in a small FIFO
// and serialises each one MSB-first, flagging the final bit with o_tx_end.
module tx_frame_buffer #(
  parameter int DATA_WIDTH = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic                               i_en,
  input  logic [DATA_WIDTH-1:0]              iv_din,
  input  logic                               i_din_valid,
  output logic                               o_din_ready,
  output logic                               o_dout,
  output logic                               o_dout_valid,
  output logic                               o_tx_end,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    ov_level
);

  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(DATA_WIDTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wrPtr;
  logic [PTR_W-1:0]      r_rdPtr;
  logic [LVL_W-1:0]      r_level;
  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [CNT_W-1:0]      r_bitCnt;

  logic w_full;
  logic w_empty;
  logic w_lastBit;
  logic w_push;
  logic w_pop;

  assign w_full    = (r_level == LVL_W'(FIFO_DEPTH));
  assign w_empty   = (r_level == '0);
  assign w_lastBit = (r_state == SHIFT) && (r_bitCnt == '0) && i_en;
  // A pop refills the shift register: immediately from IDLE, or on the last bit
  // of the current word so consecutive words run back-to-back.
  assign w_pop     = !w_empty && ((r_state == IDLE) || w_lastBit);
  assign w_push    = i_din_valid && o_din_ready;

  // Ready ignores a same-cycle pop, so a full FIFO never writes through.
  assign o_din_ready  = i_rst_n && !w_full;
  assign o_tx_end     = w_lastBit;
  assign o_dout_valid = (r_state == SHIFT);
  assign o_dout       = (r_state == SHIFT) && r_shift[DATA_WIDTH-1];
  assign ov_level     = r_level;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= iv_din;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_shift  <= '0;
      r_bitCnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_shift  <= r_mem[r_rdPtr];
            r_bitCnt <= CNT_W'(DATA_WIDTH - 1);
            r_state  <= SHIFT;
          end
        end
        SHIFT: begin
          if (i_en) begin
            if (r_bitCnt != '0) begin
              r_shift  <= {r_shift[DATA_WIDTH-2:0], 1'b0};
              r_bitCnt <= r_bitCnt - 1'b1;
            end else if (w_pop) begin
              r_shift  <= r_mem[r_rdPtr];
              r_bitCnt <= CNT_W'(DATA_WIDTH - 1);
            end else begin
              r_shift <= '0;
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
